uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding, FIFO depth
// and bit-period calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int FIFO_DEPTH = 4;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small register-based FIFO holding received words; a pop on a full FIFO frees
// room for a push on the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection with valid/ready output.
// Define UART_RX_FIFO_EN for a 4-entry output FIFO instead of a single holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    clk_req,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  input  logic                    uart_rx_ready,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_overrun
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  generate
    if (STOP_BITS < 1 || PAYLOAD_BITS < 2 || HALF_BIT < 1) begin : g_param_check
      $error("uart_rx: unsupported parameter combination");
    end
  endgenerate

  rx_state_t                state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [BIT_W-1:0]         bit_cnt_reg;
  logic [PAYLOAD_BITS-1:0]  shift_reg;
  logic                     rxd_meta_reg;
  logic                     rxd_sync_reg;
  logic                     rxd_prev_reg;
  logic                     frame_err_reg;
  logic                     overrun_reg;
  logic                     clk_req_reg;

  logic fall_edge;
  logic bit_tick;
  logic half_tick;
  logic stop_sample;
  logic word_done;
  logic pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= uart_rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  assign fall_edge   = rxd_prev_reg & ~rxd_sync_reg;
  assign bit_tick    = (cnt_reg == CNT_W'(CYCLES_PER_BIT - 1));
  assign half_tick   = (cnt_reg == CNT_W'(HALF_BIT - 1));
  assign stop_sample = uart_rx_en && (state_reg == STOP) && bit_tick;
  assign word_done   = stop_sample & rxd_sync_reg;
  assign pop         = uart_rx_valid & uart_rx_ready;

  // Only the first stop bit is sampled; extra stop bits look like idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (!uart_rx_en) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fall_edge) begin
              state_reg <= START;
              cnt_reg   <= '0;
            end
          end
          START: begin
            if (half_tick) begin
              cnt_reg     <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= rxd_sync_reg ? IDLE : RECV;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RECV: begin
            if (bit_tick) begin
              cnt_reg     <= '0;
              shift_reg   <= {rxd_sync_reg, shift_reg[PAYLOAD_BITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BIT_W'(PAYLOAD_BITS - 1)) state_reg <= STOP;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          STOP: begin
            if (bit_tick) begin
              cnt_reg       <= '0;
              state_reg     <= IDLE;
              frame_err_reg <= ~rxd_sync_reg;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Held high from reset; afterwards tracks activity or a pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_req_reg <= 1'b1;
    end else begin
      clk_req_reg <= (state_reg != IDLE) | uart_rx_valid | ~rxd_sync_reg;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_rx_fifo #(
    .WIDTH(PAYLOAD_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_done),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (uart_rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign uart_rx_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= word_done & fifo_full & ~pop;
    end
  end
`else
  logic                    valid_reg;
  logic [PAYLOAD_BITS-1:0] data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= word_done & valid_reg & ~pop;
      if (word_done && (!valid_reg || pop)) begin
        valid_reg <= 1'b1;
        data_reg  <= shift_reg;
      end else if (pop) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign uart_rx_valid = valid_reg;
  assign uart_rx_data  = data_reg;
`endif

  assign uart_rx_frame_err = frame_err_reg;
  assign uart_rx_overrun   = overrun_reg;
  assign clk_req           = clk_req_reg;

endmodule
